// File: rtl/ahb_mtx_pkg.sv
// Shared encodings for the AHB bus matrix: transfer types, burst codes,
// the input-stage error-response states and the ctrl bus field layout.
package ahb_mtx_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_INCR = 3'b001;

    // ctrl bus: {HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HMASTLOCK, 2'b00}
    localparam int CTRL_W         = 14;
    localparam int CTRL_WRITE     = 13;
    localparam int CTRL_SIZE_LSB  = 10;
    localparam int CTRL_BURST_LSB = 7;
    localparam int CTRL_PROT_LSB  = 3;
    localparam int CTRL_LOCK      = 2;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } err_st_t;

endpackage

// File: rtl/ahb_mtx_in_hold_reg.sv
// Holds an address phase that no output port could take yet and selects
// between the live master bus and the held copy for the output stages.
module ahb_mtx_in_hold_reg
    import ahb_mtx_pkg::*;
#(
    parameter int NUM_OUT = 4,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trans_valid,
    input  logic               accepted,
    input  logic [ADDR_W-1:0]  live_addr,
    input  logic [1:0]         live_trans,
    input  logic [CTRL_W-1:0]  live_ctrl,
    input  logic [NUM_OUT-1:0] live_dec,
    output logic               pend,
    output logic [ADDR_W-1:0]  addr,
    output logic [1:0]         trans,
    output logic [CTRL_W-1:0]  ctrl,
    output logic [NUM_OUT-1:0] req
);

    logic [ADDR_W-1:0]  hold_addr;
    logic [1:0]         hold_trans;
    logic [CTRL_W-1:0]  hold_ctrl;
    logic [NUM_OUT-1:0] hold_dec;
    logic               capture;

    // A transfer accepted in its own address cycle never enters the hold.
    assign capture = !pend && trans_valid && (|live_dec) && !accepted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= 1'b0;
            hold_addr  <= '0;
            hold_trans <= HTRANS_IDLE;
            hold_ctrl  <= '0;
            hold_dec   <= '0;
        end else if (capture) begin
            pend       <= 1'b1;
            hold_addr  <= live_addr;
            hold_trans <= live_trans;
            hold_ctrl  <= live_ctrl;
            hold_dec   <= live_dec;
        end else if (pend && accepted) begin
            pend <= 1'b0;
        end
    end

    // A replayed SEQ starts a fresh burst at the slave, so it goes out as NONSEQ/INCR.
    always_comb begin
        addr  = live_addr;
        trans = live_trans;
        ctrl  = live_ctrl;
        req   = trans_valid ? live_dec : '0;
        if (pend) begin
            addr  = hold_addr;
            trans = hold_trans;
            ctrl  = hold_ctrl;
            req   = hold_dec;
            if (hold_trans == HTRANS_SEQ) begin
                trans                         = HTRANS_NONSEQ;
                ctrl[CTRL_BURST_LSB +: 3]     = HBURST_INCR;
            end
        end
    end

endmodule

// File: rtl/ahb_mtx_in_stage.sv
// Per-master input stage of the AHB bus matrix: requests output ports, replays
// stalled address phases, routes data-phase responses and answers unmapped accesses.
module ahb_mtx_in_stage
    import ahb_mtx_pkg::*;
#(
    parameter int NUM_OUT = 4,
    parameter int ADDR_W  = 32
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSELS,
    input  logic [ADDR_W-1:0]  HADDRS,
    input  logic [1:0]         HTRANSS,
    input  logic               HWRITES,
    input  logic [2:0]         HSIZES,
    input  logic [2:0]         HBURSTS,
    input  logic [3:0]         HPROTS,
    input  logic               HMASTLOCKS,
    input  logic               HREADYS,
    output logic               HREADYOUTS,
    output logic               HRESPS,
    input  logic [NUM_OUT-1:0] dec_sel,
    output logic [NUM_OUT-1:0] req_out,
    input  logic [NUM_OUT-1:0] addr_accept,
    output logic [ADDR_W-1:0]  HADDRO,
    output logic [1:0]         HTRANSO,
    output logic [CTRL_W-1:0]  ctrl_o,
    input  logic [NUM_OUT-1:0] HREADYOUTM,
    input  logic [NUM_OUT-1:0] HRESPM
);

    logic               trans_valid;
    logic               unmapped;
    logic               accepted;
    logic               pend;
    logic               data_valid;
    logic               data_ready;
    logic               data_resp;
    logic [NUM_OUT-1:0] req;
    logic [NUM_OUT-1:0] data_sel;
    logic [1:0]         trans;
    logic [CTRL_W-1:0]  live_ctrl;
    err_st_t            err_st;
    err_st_t            err_nxt;

    assign trans_valid = HSELS & HREADYS & HTRANSS[1];
    assign unmapped    = trans_valid & ~(|dec_sel);
    assign live_ctrl   = {HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, 2'b00};

    ahb_mtx_in_hold_reg #(
        .NUM_OUT (NUM_OUT),
        .ADDR_W  (ADDR_W)
    ) u_hold (
        .clk         (HCLK),
        .rst         (HRESET),
        .trans_valid (trans_valid),
        .accepted    (accepted),
        .live_addr   (HADDRS),
        .live_trans  (HTRANSS),
        .live_ctrl   (live_ctrl),
        .live_dec    (dec_sel),
        .pend        (pend),
        .addr        (HADDRO),
        .trans       (trans),
        .ctrl        (ctrl_o),
        .req         (req)
    );

    // Reset silences the request and transfer lines combinationally, not just at the next edge.
    assign req_out  = HRESET ? '0 : req;
    assign HTRANSO  = HRESET ? HTRANS_IDLE : trans;
    assign accepted = |(addr_accept & req_out);

    assign data_ready = |(HREADYOUTM & data_sel);
    assign data_resp  = |(HRESPM & data_sel);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            data_valid <= 1'b0;
            data_sel   <= '0;
        end else if (accepted) begin
            data_valid <= 1'b1;
            data_sel   <= addr_accept & req_out;
        end else if (data_ready) begin
            data_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            err_st <= ST_OK;
        end else begin
            err_st <= err_nxt;
        end
    end

    always_comb begin
        err_nxt = err_st;
        case (err_st)
            ST_OK:   err_nxt = unmapped ? ST_ERR1 : ST_OK;
            ST_ERR1: err_nxt = ST_ERR2;
            ST_ERR2: err_nxt = unmapped ? ST_ERR1 : ST_OK;
            default: err_nxt = ST_OK;
        endcase
    end

    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
        if (pend) begin
            HREADYOUTS = 1'b0;
        end else if (err_st == ST_ERR1) begin
            HREADYOUTS = 1'b0;
        end else if (err_st == ST_ERR2) begin
            HREADYOUTS = 1'b1;
        end else if (data_valid) begin
            HREADYOUTS = data_ready;
        end
        if (err_st != ST_OK) begin
            HRESPS = 1'b1;
        end else if (data_valid) begin
            HRESPS = data_resp;
        end
    end

endmodule
